dp_share_arbiter: RTL and testbench

//  Shares one datapath/control-unit pair (start/valid handshake) between two requesters, A and B.

---
 rtl/dp_share_arbiter.sv | 105 ++++++++++
 tb/tb_dp_share_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_share_arbiter.sv
// Two-requester round-robin front end for a single start/valid datapath.
// Captures the winner's operand, launches the run, and returns the result or a timeout error.
module dp_share_arbiter #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 15
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_a,
   input  logic [WIDTH-1:0] x_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] x_b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             done_a,
   output logic             done_b,
   output logic             err_a,
   output logic             err_b,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   input  logic             dp_ready,
   output logic             dp_start,
   output logic [WIDTH-1:0] dp_x,
   input  logic             dp_valid,
   input  logic [WIDTH-1:0] dp_result,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   state_t     state_nx;
   logic       owner;    // 0 = A, 1 = B
   logic       rr_ptr;   // preferred requester when both ask
   logic [7:0] cnt;
   logic       take;
   logic       winner;

   always_comb begin
      take   = (state == S_IDLE) && dp_ready && (req_a || req_b);
      winner = (req_a && req_b) ? rr_ptr : req_b;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (take) state_nx = S_START;
         S_START: state_nx = S_WAIT;
         // A valid arriving on the final allowed cycle still counts as success.
         S_WAIT: begin
            if (dp_valid)             state_nx = S_DONE;
            else if (cnt == CNT_LAST) state_nx = S_ERR;
         end
         S_DONE:  state_nx = S_IDLE;
         S_ERR:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Grants are gated by reset so nothing is offered while reset is held.
   always_comb begin
      gnt_a     = take && !winner && reset;
      gnt_b     = take &&  winner && reset;
      dp_start  = (state == S_START);
      done_a    = (state == S_DONE) && !owner;
      done_b    = (state == S_DONE) &&  owner;
      err_a     = (state == S_ERR)  && !owner;
      err_b     = (state == S_ERR)  &&  owner;
      busy      = (state != S_IDLE);
      dbg_state = state;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         owner  <= 1'b0;
         rr_ptr <= 1'b0;
         cnt    <= 8'd0;
         result <= '0;
         dp_x   <= '0;
      end else begin
         if (take) begin
            owner <= winner;
            dp_x  <= winner ? x_b : x_a;
         end
         if (state == S_START)     cnt <= 8'd0;
         else if (state == S_WAIT) cnt <= cnt + 8'd1;
         if ((state == S_WAIT) && dp_valid) result <= dp_result;
         if ((state == S_DONE) || (state == S_ERR)) rr_ptr <= ~owner;
      end
   end

endmodule

// File: tb/tb_dp_share_arbiter.sv
// Randomized bench for dp_share_arbiter: a transaction-level model predicts grants,
// starts and completions with their cycle stamps; a negedge monitor pops and compares.
module tb_dp_share_arbiter;

   localparam int W  = 8;
   localparam int TO = 4;

   logic         clock = 1'b0;
   logic         reset;
   logic         req_a, req_b;
   logic [W-1:0] x_a, x_b;
   logic         gnt_a, gnt_b, done_a, done_b, err_a, err_b;
   logic [W-1:0] result;
   logic         busy;
   logic         dp_ready, dp_start, dp_valid;
   logic [W-1:0] dp_x, dp_result;
   logic [2:0]   dbg_state;

   dp_share_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .req_a(req_a), .x_a(x_a), .req_b(req_b), .x_b(x_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
      .err_a(err_a), .err_b(err_b), .result(result), .busy(busy),
      .dp_ready(dp_ready), .dp_start(dp_start), .dp_x(dp_x),
      .dp_valid(dp_valid), .dp_result(dp_result), .dbg_state(dbg_state)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int           cyc;
      logic         who;   // 0 = A, 1 = B
      logic         err;
      logic [W-1:0] val;
   } ev_t;

   ev_t gnt_q[$];
   ev_t start_q[$];
   ev_t cmp_q[$];

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic         rr;
   int           busy_left;
   logic [W-1:0] last_result;
   logic         exp_busy;
   int           wait_lo, wait_hi, valid_cyc;
   logic [W-1:0] valid_res;
   bit           drop_a, drop_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_clear();
      gnt_q.delete(); start_q.delete(); cmp_q.delete();
      rr = 1'b0; busy_left = 0; last_result = '0; exp_busy = 1'b0;
      wait_lo = -1; wait_hi = -2; valid_cyc = -1; valid_res = '0;
      drop_a = 1'b0; drop_b = 1'b0;
      req_a = 1'b0; req_b = 1'b0; dp_valid = 1'b0;
   endtask

   // One cycle of stimulus plus prediction. req_mode: 0 none, 1 random, 2 always.
   // ready_mode: 0 random, 1 low, 2 high.
   task automatic drive_cycle(input int ready_mode, input int req_mode, input bit no_valid);
      logic         win;
      logic [W-1:0] xw, r;
      int           d;
      if (drop_a) begin req_a = 1'b0; drop_a = 1'b0; end
      if (drop_b) begin req_b = 1'b0; drop_b = 1'b0; end
      if (req_mode != 0) begin
         if (!req_a && (req_mode == 2 || $urandom_range(0, 2) == 0)) begin
            req_a = 1'b1; x_a = W'($urandom);
         end
         if (!req_b && (req_mode == 2 || $urandom_range(0, 2) == 0)) begin
            req_b = 1'b1; x_b = W'($urandom);
         end
      end
      case (ready_mode)
         1:       dp_ready = 1'b0;
         2:       dp_ready = 1'b1;
         default: dp_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (cyc >= wait_lo && cyc <= wait_hi) begin
         dp_valid  = (cyc == valid_cyc);
         dp_result = dp_valid ? valid_res : W'($urandom);
      end else begin
         dp_valid  = 1'($urandom_range(0, 1));
         dp_result = W'($urandom);
      end
      exp_busy = (busy_left != 0);
      if (busy_left != 0) begin
         busy_left--;
      end else if (dp_ready && (req_a || req_b)) begin
         win = (req_a && req_b) ? rr : req_b;
         xw  = win ? x_b : x_a;
         d   = no_valid ? TO + 2 : $urandom_range(0, TO + 2);
         gnt_q.push_back('{cyc, win, 1'b0, xw});
         start_q.push_back('{cyc + 1, win, 1'b0, xw});
         wait_lo = cyc + 2;
         wait_hi = cyc + 1 + TO;
         if (d < TO) begin
            r         = W'($urandom);
            valid_cyc = cyc + 2 + d;
            valid_res = r;
            cmp_q.push_back('{cyc + 3 + d, win, 1'b0, r});
            last_result = r;
            busy_left   = 3 + d;
         end else begin
            valid_cyc = -1;
            cmp_q.push_back('{cyc + 2 + TO, win, 1'b1, last_result});
            busy_left = TO + 2;
         end
         rr = ~win;
         if (win) drop_b = 1'b1;
         else     drop_a = 1'b1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      do begin
         @(posedge clock); #1;
         drive_cycle(0, 0, 0);
         n++;
      end while ((req_a || req_b || drop_a || drop_b || busy_left != 0) && n < 200);
      if (n >= 200) chk("drain_bound", 32'd0, 32'd1);
   endtask

   // Monitor
   initial begin
      ev_t e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            chk("reset_pulses", {24'd0, gnt_a, gnt_b, done_a, done_b, err_a, err_b, dp_start, busy}, 32'd0);
            chk("reset_result", result, 32'd0);
            chk("reset_dp_x", dp_x, 32'd0);
            chk("reset_state", dbg_state, 32'd0);
         end else begin
            chk("one_hot", ($countones({gnt_a, gnt_b, done_a, done_b, err_a, err_b}) <= 1), 32'd1);
            chk("busy", busy, exp_busy);
            if (gnt_a || gnt_b) begin
               if (gnt_q.size() == 0) chk("gnt_unexpected", 32'd1, 32'd0);
               else begin
                  e = gnt_q.pop_front();
                  chk("gnt_cycle", cyc, e.cyc);
                  chk("gnt_who", gnt_b, e.who);
               end
            end else if (gnt_q.size() != 0 && gnt_q[0].cyc <= cyc) begin
               chk("gnt_missing", 32'd0, 32'd1);
               void'(gnt_q.pop_front());
            end
            if (dp_start) begin
               if (start_q.size() == 0) chk("start_unexpected", 32'd1, 32'd0);
               else begin
                  e = start_q.pop_front();
                  chk("start_cycle", cyc, e.cyc);
                  chk("start_dp_x", dp_x, e.val);
               end
            end else if (start_q.size() != 0 && start_q[0].cyc <= cyc) begin
               chk("start_missing", 32'd0, 32'd1);
               void'(start_q.pop_front());
            end
            if (done_a || done_b || err_a || err_b) begin
               if (cmp_q.size() == 0) chk("cmp_unexpected", 32'd1, 32'd0);
               else begin
                  e = cmp_q.pop_front();
                  chk("cmp_cycle", cyc, e.cyc);
                  chk("cmp_owner", done_b || err_b, e.who);
                  chk("cmp_is_err", err_a || err_b, e.err);
                  chk("cmp_result", result, e.val);
               end
            end else if (cmp_q.size() != 0 && cmp_q[0].cyc <= cyc) begin
               chk("cmp_missing", 32'd0, 32'd1);
               void'(cmp_q.pop_front());
            end
         end
      end
   end

   // Main sequence
   initial begin
      reset = 1'b0;
      x_a = '0; x_b = '0; dp_ready = 1'b0; dp_result = '0;
      model_clear();
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      drive_cycle(0, 1, 0);

      for (int i = 0; i < 2500; i++) begin
         @(posedge clock); #1;
         drive_cycle(0, 1, 0);
      end
      drain();

      // Both requesters held: grants must alternate.
      for (int i = 0; i < 60; i++) begin
         @(posedge clock); #1;
         drive_cycle(2, 2, 0);
      end
      drain();

      // Datapath not ready: the request must wait, then win at once.
      req_a = 1'b1; x_a = 8'h05;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         drive_cycle(1, 0, 0);
      end
      @(posedge clock); #1;
      drive_cycle(2, 0, 0);
      drain();

      // Reset while a run sits in WAIT, then a fresh request from B.
      req_b = 1'b1; x_b = 8'h5A;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock); #1;
         drive_cycle(2, 0, 1);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      model_clear();
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      req_b = 1'b1; x_b = 8'hC3;
      drive_cycle(2, 0, 0);
      drain();

      for (int i = 0; i < 500; i++) begin
         @(posedge clock); #1;
         drive_cycle(0, 1, 0);
      end
      drain();

      @(posedge clock); #1;
      drive_cycle(0, 0, 0);
      @(negedge clock); #1;
      chk("queues_empty", gnt_q.size() + start_q.size() + cmp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
